long_delay_sched: RTL
=====================

Name: long_delay_sched

Overview:
- Controller that sequences one dual-port SRAM bank (one write port, one read port, 1-cycle read latency) as a programmable long-delay line.
- Every word presented on data_in is emitted on data_out exactly cfg_delay cycles later.
- It generates the write/read enables and the circular addresses, and frames one burst of cfg_len words per start.
- It sits between the stream producer and a memtile's SRAM macro, replacing fixed address-generator configuration for delay-only use.

Parameters:
- DATA_WIDTH, 16, word width.
- ADDR_WIDTH, 9, SRAM address width; DEPTH = 2**ADDR_WIDTH words.
- LEN_WIDTH, 16, width of burst-length config.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  launch one burst; sampled only in IDLE.
- cfg_delay  in  ADDR_WIDTH+1  delay in cycles; legal range 2..DEPTH.
- cfg_len  in  LEN_WIDTH  words in burst; legal range 1..2**LEN_WIDTH-1.
- in_ready  out  1  high on cycles where data_in is consumed.
- data_in  in  DATA_WIDTH  input word, taken when in_ready=1 (no backpressure; producer must supply).
- sram_wen  out  1  SRAM write enable.
- sram_waddr  out  ADDR_WIDTH  write address.
- sram_wdata  out  DATA_WIDTH  write data (combinational copy of data_in).
- sram_ren  out  1  SRAM read enable.
- sram_raddr  out  ADDR_WIDTH  read address.
- sram_rdata  in  DATA_WIDTH  read data, valid 1 cycle after sram_ren.
- out_valid  out  1  data_out valid.
- data_out  out  DATA_WIDTH  delayed word (sram_rdata passthrough, qualified by out_valid).
- busy  out  1  high in ACTIVE.
- done  out  1  one-cycle pulse at burst end.
- cfg_err  out  1  one-cycle pulse on rejected start.

Behaviour:
- Reset, and the first cycle after rst deasserts:
  - state=IDLE.
  - All enables, out_valid, busy, done and cfg_err are 0.
  - All addresses and counters are 0.
  - data_out is don't-care while out_valid=0.
- States are IDLE and ACTIVE.
- IDLE:
  - start=1 with legal config: latch D=cfg_delay and N=cfg_len, clear t and both address counters, go to ACTIVE next cycle.
  - start=1 with D<2, D>DEPTH or N=0: pulse cfg_err the next cycle and stay IDLE.
- ACTIVE uses a burst cycle counter t of LEN_WIDTH+ADDR_WIDTH+1 bits. t=0 on the first ACTIVE cycle and increments every cycle. All enables are combinational from t:
  - sram_wen = in_ready = (t < N).
  - sram_ren = (t >= D-1) && (t < N+D-1).
  - out_valid is sram_ren registered by 1 cycle, so word k (written at t=k) appears on data_out at t=k+D.
- Addresses:
  - sram_waddr = wptr; wptr increments mod DEPTH on each write.
  - sram_raddr = rptr; rptr increments mod DEPTH on each read.
  - Both pointers start at 0; they wrap naturally through the ADDR_WIDTH overflow.
  - D ≤ DEPTH guarantees a slot is never overwritten before it is read. When D=DEPTH, the write in the same cycle targets rptr-1, never rptr.
- The gap case N < D-1 is legal: there are cycles with neither wen nor ren, and t keeps running.
- End of burst:
  - At t = N+D-1 (the cycle carrying the last out_valid), done=1.
  - Next cycle: state=IDLE, busy=0.
  - A start in the cycle after done is accepted normally.
- start while ACTIVE is ignored: no cfg_err, and config is not re-latched.
- Simultaneous read and write of the same address cannot occur for legal configs. The controller does not depend on SRAM collision behaviour.
- rst mid-burst:
  - Immediate return to reset values on the next edge.
  - An in-flight read's out_valid is suppressed.
  - SRAM contents are not cleared and not relied upon.
- cfg_delay and cfg_len are ignored outside the IDLE start cycle.

Test Plan:
- D=61, N=100, data_in=ramp 0..99: out_valid high for 100 cycles, starting at t=61 with value 0, ending at t=160 with value 99. done at t=160; in_ready high for t=0..99.
- D=2, N=5: ren at t=1..5; data_out 0..4 at t=2..6; done at t=6; raddr sequence 0,1,2,3,4.
- D=DEPTH=512, N=1200, random data: every output equals the input 512 cycles earlier. Both pointers wrap at 511→0 with no corruption.
- D=40, N=10: wen at t=0..9; ren at t=39..48; no enables at t=10..38; outputs correct; done at t=49.
- Illegal starts D=1, D=513, N=0: cfg_err pulse each time, busy stays 0, no enables asserted. A start pulsed during ACTIVE is ignored, with timing unchanged.
- rst asserted at t=70 of a D=61, N=100 burst: next cycle all outputs are 0 and state is IDLE. A new burst D=3, N=4 then produces 4 correct outputs at t=3..6.

Source files
------------

// File: rtl/long_delay_sched_if.sv
// SRAM port bundle between the delay-line controller and a dual-port macro.
// master drives the write/read ports, slave returns read data one cycle later.
interface long_delay_sched_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 9
);
    logic                  wen;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  ren;
    logic [ADDR_WIDTH-1:0] raddr;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (
        output wen, waddr, wdata, ren, raddr,
        input  rdata
    );

    modport slave (
        input  wen, waddr, wdata, ren, raddr,
        output rdata
    );
endinterface

// File: rtl/long_delay_sched.sv
// Long-delay line controller: circular write/read addressing over one SRAM
// bank so each input word reappears exactly cfg_delay cycles later.
module long_delay_sched #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 9,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   cfg_delay,
    input  logic [LEN_WIDTH-1:0]  cfg_len,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] data_in,
    long_delay_sched_if.master    sram,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  busy,
    output logic                  done,
    output logic                  cfg_err
);
    localparam int DW1 = ADDR_WIDTH + 1;
    localparam int TW  = LEN_WIDTH + ADDR_WIDTH + 1;
    localparam logic [DW1-1:0] DEPTH = DW1'(1) << ADDR_WIDTH;

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                state;
    logic [DW1-1:0]        d_q;
    logic [LEN_WIDTH-1:0]  n_q;
    logic [TW-1:0]         t;
    logic [ADDR_WIDTH-1:0] wptr;
    logic [ADDR_WIDTH-1:0] rptr;
    logic                  out_valid_q;
    logic                  cfg_err_q;

    logic          active;
    logic          cfg_ok;
    logic [TW-1:0] rd_start;
    logic [TW-1:0] rd_end;
    logic          wen;
    logic          ren;

    assign active   = (state == ACTIVE);
    assign cfg_ok   = (cfg_delay >= DW1'(2)) && (cfg_delay <= DEPTH)
                   && (cfg_len != '0);
    assign rd_start = TW'(d_q) - TW'(1);
    // rd_end is also the cycle carrying the last out_valid
    assign rd_end   = TW'(n_q) + TW'(d_q) - TW'(1);

    assign wen = active && (t < TW'(n_q));
    assign ren = active && (t >= rd_start) && (t < rd_end);

    assign in_ready   = wen;
    assign sram.wen   = wen;
    assign sram.waddr = wptr;
    assign sram.wdata = data_in;
    assign sram.ren   = ren;
    assign sram.raddr = rptr;

    assign out_valid = out_valid_q;
    assign data_out  = sram.rdata;
    assign busy      = active;
    assign done      = active && (t == rd_end);
    assign cfg_err   = cfg_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            d_q         <= '0;
            n_q         <= '0;
            t           <= '0;
            wptr        <= '0;
            rptr        <= '0;
            out_valid_q <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            out_valid_q <= ren;
            cfg_err_q   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (cfg_ok) begin
                            d_q   <= cfg_delay;
                            n_q   <= cfg_len;
                            t     <= '0;
                            wptr  <= '0;
                            rptr  <= '0;
                            state <= ACTIVE;
                        end else begin
                            cfg_err_q <= 1'b1;
                        end
                    end
                end
                ACTIVE: begin
                    t <= t + TW'(1);
                    if (wen) wptr <= wptr + ADDR_WIDTH'(1);
                    if (ren) rptr <= rptr + ADDR_WIDTH'(1);
                    if (t == rd_end) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
